// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Instruction-fetch front end. Owns the architectural PC, issues
//            word requests to instruction memory over a req/ready handshake,
//            presents fetched instructions to decode, flags misaligned or
//            out-of-window fetch addresses, and buffers flush redirects that
//            arrive while a memory access is outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] curr_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic [31:0] badvaddr
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // Legal window bounds, widened to 33 bits so the upper bound cannot wrap.
    localparam logic [32:0] C_WIN_LO = {1'b0, IM_BASE};
    localparam logic [32:0] C_WIN_HI = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        fetch_fault_q;
    logic [31:0] badvaddr_q;
    logic        pending_flush_q;
    logic [31:0] pending_pc_q;

    logic [32:0] w_pc_ext;
    logic        w_fault;

    // Fetch-address legality: word alignment and window membership of the PC.
    always_comb begin
        w_pc_ext = {1'b0, pc_q};
        w_fault  = (pc_q[1:0] != 2'b00)
                 | (w_pc_ext < C_WIN_LO)
                 | (w_pc_ext >= C_WIN_HI);
    end

    // Memory request: a fresh legal request in S_REQ, or held through S_WAIT;
    // reset masks it so an abandoned access is not re-presented.
    always_comb begin
        imem_req  = !reset && ((state_q == S_WAIT) ||
                               ((state_q == S_REQ) && !w_fault));
        imem_addr = pc_q;
    end

    assign curr_pc     = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign badvaddr    = badvaddr_q;

    // Fetch sequencer: PC update, handshake tracking, decode-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_REQ;
            pc_q            <= RESET_PC;
            instr_q         <= 32'h0;
            instr_valid_q   <= 1'b0;
            fetch_fault_q   <= 1'b0;
            badvaddr_q      <= 32'h0;
            pending_flush_q <= 1'b0;
            pending_pc_q    <= 32'h0;
        end else begin
            case (state_q)
                S_REQ: begin
                    pending_flush_q <= 1'b0;
                    if (flush) begin
                        // Redirect wins; any data returned this cycle is dropped.
                        pc_q <= flush_pc;
                    end else if (w_fault) begin
                        // Deliver a fault bubble instead of touching memory.
                        instr_q       <= 32'h0;
                        fetch_fault_q <= 1'b1;
                        badvaddr_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_VALID;
                    end else if (imem_ready) begin
                        instr_q       <= imem_rdata;
                        fetch_fault_q <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_VALID;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_ready) begin
                        if (flush) begin
                            // A same-cycle flush is the most recent target.
                            pc_q            <= flush_pc;
                            pending_flush_q <= 1'b0;
                            state_q         <= S_REQ;
                        end else if (pending_flush_q) begin
                            pc_q            <= pending_pc_q;
                            pending_flush_q <= 1'b0;
                            state_q         <= S_REQ;
                        end else begin
                            instr_q       <= imem_rdata;
                            fetch_fault_q <= 1'b0;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_VALID;
                        end
                    end else if (flush) begin
                        // Access still in flight: remember the latest redirect.
                        pending_flush_q <= 1'b1;
                        pending_pc_q    <= flush_pc;
                    end
                end

                S_VALID: begin
                    if (flush) begin
                        pc_q          <= flush_pc;
                        instr_valid_q <= 1'b0;
                        fetch_fault_q <= 1'b0;
                        state_q       <= S_REQ;
                    end else if (!stall) begin
                        pc_q          <= next_pc;
                        instr_valid_q <= 1'b0;
                        fetch_fault_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end

                default: begin
                    state_q       <= S_REQ;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
